lcd_phy_arb: RTL and testbench

- Shares the single 8-bit LCD PHY between two requesters: the command player byte stream and a 16-bit pixel stream.
- Pixel frames are started by a control pulse. They are optionally aligned to the panel tearing strobe (fmark).
- Each pixel is serialised as two bytes with RS=1.
- Command sequences are never split. Pixel frames are never interrupted.

---
 rtl/lcd_phy_arb.sv | 138 +++++++++++++
 tb/tb_lcd_phy_arb.sv | 385 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_phy_arb.sv
// Arbitrates the shared 8-bit LCD PHY between the command player and the 16-bit pixel stream.
// Command sequences are atomic, and pixel frames run to completion once started.
module lcd_phy_arb #(
  parameter int NPIX_W = 17
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        cmd_data,
  input  logic              cmd_rs,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_busy,
  input  logic [15:0]       pix_data,
  input  logic              pix_valid,
  output logic              pix_ready,
  input  logic              ctl_start,
  input  logic              ctl_sync,
  input  logic [NPIX_W-1:0] ctl_npix,
  output logic              ctl_busy,
  output logic              ctl_done,
  input  logic              phy_fmark_stb,
  output logic [7:0]        phy_data,
  output logic              phy_rs,
  output logic              phy_valid,
  input  logic              phy_ready
);

  // state   | meaning
  // IDLE    | PHY idle; picks commands first, then any pending frame
  // CMD     | command player owns the PHY until valid and busy both drop
  // FM_WAIT | synced frame pending, waiting for the tearing strobe
  // PIX     | streaming pixels, high byte then low byte
  typedef enum logic [1:0] {IDLE, CMD, FM_WAIT, PIX} state_t;

  state_t            state;
  logic              phase;
  logic              start_pend;
  logic              sync_q;
  logic [NPIX_W-1:0] npix_q;
  logic [NPIX_W-1:0] count;
  logic              cmd_req;
  logic              pix_xfer;

  assign cmd_req  = cmd_valid | cmd_busy;
  assign pix_xfer = pix_valid & phy_ready;
  assign ctl_busy = start_pend | (state == PIX);

  always_comb begin
    phy_data  = '0;
    phy_rs    = 1'b0;
    phy_valid = 1'b0;
    cmd_ready = 1'b0;
    pix_ready = 1'b0;
    case (state)
      CMD: begin
        phy_data  = cmd_data;
        phy_rs    = cmd_rs;
        phy_valid = cmd_valid;
        cmd_ready = phy_ready;
      end
      PIX: begin
        phy_data  = phase ? pix_data[7:0] : pix_data[15:8];
        phy_rs    = 1'b1;
        phy_valid = pix_valid;
        pix_ready = phy_ready & pix_valid & phase;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      phase      <= 1'b0;
      start_pend <= 1'b0;
      sync_q     <= 1'b0;
      npix_q     <= '0;
      count      <= '0;
      ctl_done   <= 1'b0;
    end else begin
      ctl_done <= 1'b0;
      // Requests are only latched while nothing is pending or streaming.
      if (ctl_start && !ctl_busy) begin
        start_pend <= 1'b1;
        sync_q     <= ctl_sync;
        npix_q     <= ctl_npix;
      end
      case (state)
        IDLE: begin
          if (cmd_req) begin
            state <= CMD;
          end else if (start_pend) begin
            if (npix_q == '0) begin
              start_pend <= 1'b0;
              ctl_done   <= 1'b1;
            end else if (sync_q) begin
              state <= FM_WAIT;
            end else begin
              state      <= PIX;
              start_pend <= 1'b0;
              count      <= npix_q - NPIX_W'(1);
              phase      <= 1'b0;
            end
          end
        end
        CMD: begin
          if (!cmd_req) state <= IDLE;
        end
        FM_WAIT: begin
          // The strobe wins over a simultaneous command; a preempted wait keeps its pending frame.
          if (phy_fmark_stb) begin
            state      <= PIX;
            start_pend <= 1'b0;
            count      <= npix_q - NPIX_W'(1);
            phase      <= 1'b0;
          end else if (cmd_req) begin
            state <= CMD;
          end
        end
        PIX: begin
          if (pix_xfer) begin
            phase <= ~phase;
            if (phase) begin
              if (count == '0) begin
                state    <= IDLE;
                ctl_done <= 1'b1;
              end else begin
                count <= count - NPIX_W'(1);
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_phy_arb.sv
// Scoreboard bench for lcd_phy_arb: stimulus pushes the expected PHY byte stream,
// a negedge monitor pops and compares every PHY transfer and every ctl_done pulse.
module tb_lcd_phy_arb;
  localparam int NPIX_W = 17;

  logic              clk = 1'b0;
  logic              rst;
  logic [7:0]        cmd_data;
  logic              cmd_rs;
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_busy;
  logic [15:0]       pix_data;
  logic              pix_valid;
  logic              pix_ready;
  logic              ctl_start;
  logic              ctl_sync;
  logic [NPIX_W-1:0] ctl_npix;
  logic              ctl_busy;
  logic              ctl_done;
  logic              phy_fmark_stb;
  logic [7:0]        phy_data;
  logic              phy_rs;
  logic              phy_valid;
  logic              phy_ready;

  always #5 clk = ~clk;

  lcd_phy_arb #(.NPIX_W(NPIX_W)) dut (
    .clk(clk), .rst(rst),
    .cmd_data(cmd_data), .cmd_rs(cmd_rs), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_busy(cmd_busy),
    .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .ctl_start(ctl_start), .ctl_sync(ctl_sync), .ctl_npix(ctl_npix),
    .ctl_busy(ctl_busy), .ctl_done(ctl_done),
    .phy_fmark_stb(phy_fmark_stb),
    .phy_data(phy_data), .phy_rs(phy_rs), .phy_valid(phy_valid), .phy_ready(phy_ready)
  );

  // kind: 0 command byte, 1 pixel high byte, 2 pixel low byte
  typedef struct packed {
    logic [7:0] d;
    logic       rs;
    logic [1:0] kind;
    logic       last;
  } ent_t;

  ent_t        exp_q[$];
  logic [15:0] pix_q[$];
  logic [15:0] stage_pix[$];
  logic [8:0]  cmd_stage[$];
  int          checks = 0;
  int          failures = 0;
  int          xfer = 0;
  int          zero_tok = 0;
  bit          done_due = 1'b0;
  bit          gap_en = 1'b0;
  bit          rdy_rand = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor / scoreboard
  initial begin
    ent_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (done_due) begin
          done_due = 1'b0;
          chk("done_after_last_byte{done,busy}", 32'({ctl_done, ctl_busy}), 32'h2);
        end else if (ctl_done) begin
          if (zero_tok > 0) begin
            zero_tok--;
            chk("zero_frame_done_busy", 32'(ctl_busy), 32'h0);
          end else begin
            chk("unexpected_ctl_done", 32'(ctl_done), 32'h0);
          end
        end
        if (phy_valid && phy_ready) begin
          xfer++;
          if (exp_q.size() == 0) begin
            chk("unexpected_phy_byte{valid,rs,data}", 32'({phy_valid, phy_rs, phy_data}), 32'h0);
          end else begin
            e = exp_q.pop_front();
            chk("phy_byte{rs,data}", 32'({phy_rs, phy_data}), 32'({e.rs, e.d}));
            chk("pix_ready_on_byte", 32'(pix_ready), 32'(e.kind == 2'd2));
            chk("cmd_ready_on_byte", 32'(cmd_ready), 32'(e.kind == 2'd0));
            if (e.last) done_due = 1'b1;
          end
        end
      end
    end
  end

  // Pixel source: holds each pixel until popped, optionally stalls after a high byte.
  initial begin
    int  pix_rd = 0;
    int  gap = 0;
    bit  pop, hi;
    pix_valid = 1'b0;
    pix_data  = 16'h0;
    forever begin
      @(negedge clk);
      pop = pix_valid & pix_ready;
      hi  = gap_en & pix_valid & phy_valid & phy_ready & ~pix_ready;
      @(posedge clk);
      #1;
      if (rst) begin
        pix_rd    = pix_q.size();
        gap       = 0;
        pix_valid = 1'b0;
      end else begin
        if (pop) pix_rd++;
        if (hi && $urandom_range(0, 1) == 1) gap = $urandom_range(1, 3);
        if (gap > 0) begin
          gap--;
          pix_valid = 1'b0;
        end else begin
          pix_valid = pix_rd < pix_q.size();
          pix_data  = pix_valid ? pix_q[pix_rd] : 16'h0;
        end
      end
    end
  end

  initial begin
    phy_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      phy_ready = rdy_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
  end

  task automatic report();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
  endtask

  initial begin
    #300000;
    failures++;
    $display("FAIL watchdog simulation time limit reached");
    report();
    $fatal(1, "watchdog");
  end

  task automatic load_frame();
    foreach (stage_pix[i]) pix_q.push_back(stage_pix[i]);
  endtask

  task automatic push_frame();
    if (stage_pix.size() == 0) zero_tok++;
    foreach (stage_pix[i]) begin
      exp_q.push_back('{d: stage_pix[i][15:8], rs: 1'b1, kind: 2'd1, last: 1'b0});
      exp_q.push_back('{d: stage_pix[i][7:0], rs: 1'b1, kind: 2'd2,
                        last: (i == stage_pix.size() - 1)});
    end
  endtask

  task automatic rand_frame(input int n);
    stage_pix.delete();
    for (int i = 0; i < n; i++) stage_pix.push_back(16'($urandom));
  endtask

  task automatic start_pulse(input bit sync, input int n);
    ctl_sync  = sync;
    ctl_npix  = NPIX_W'(n);
    ctl_start = 1'b1;
    tick();
    ctl_start = 1'b0;
  endtask

  task automatic fmark_pulse(input bit push);
    phy_fmark_stb = 1'b1;
    if (push) push_frame();
    tick();
    phy_fmark_stb = 1'b0;
  endtask

  task automatic cmd_send();
    bit ok;
    foreach (cmd_stage[i])
      exp_q.push_back('{d: cmd_stage[i][7:0], rs: cmd_stage[i][8], kind: 2'd0, last: 1'b0});
    cmd_busy = 1'b1;
    foreach (cmd_stage[i]) begin
      cmd_data  = cmd_stage[i][7:0];
      cmd_rs    = cmd_stage[i][8];
      cmd_valid = 1'b1;
      ok = 1'b0;
      for (int c = 0; c < 400; c++) begin
        @(negedge clk);
        if (cmd_ready) begin
          ok = 1'b1;
          break;
        end
      end
      if (!ok) chk("cmd_byte_accept_timeout", 32'(ok), 32'h1);
      tick();
      cmd_valid = 1'b0;
      if ($urandom_range(0, 1) == 1) tick();
    end
    cmd_busy = 1'b0;
    cmd_stage.delete();
  endtask

  task automatic wait_idle(input int bound);
    bit ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      if (exp_q.size() == 0 && !done_due && zero_tok == 0 && !ctl_busy && !ctl_done) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    chk("scenario_complete_timeout", 32'(ok), 32'h1);
  endtask

  task automatic wait_xfers(input int n);
    int x0 = xfer;
    bit ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (xfer - x0 >= n) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk);
    end
    if (!ok) chk("wait_transfers_timeout", 32'(ok), 32'h1);
  endtask

  initial begin
    rst = 1'b1;
    cmd_data = 8'h0; cmd_rs = 1'b0; cmd_valid = 1'b0; cmd_busy = 1'b0;
    ctl_start = 1'b0; ctl_sync = 1'b0; ctl_npix = '0; phy_fmark_stb = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_phy_valid", 32'(phy_valid), 32'h0);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'h0);
    chk("rst_pix_ready", 32'(pix_ready), 32'h0);
    chk("rst_ctl_busy", 32'(ctl_busy), 32'h0);
    chk("rst_ctl_done", 32'(ctl_done), 32'h0);
    rst = 1'b0;
    tick();

    // Command only
    cmd_stage = '{9'h02A, 9'h000, 9'h110};
    cmd_send();
    repeat (3) tick();
    chk("cmd_back_to_idle{valid,cmd_ready}", 32'({phy_valid, cmd_ready}), 32'h0);
    wait_idle(100);

    // Unsynced frame with fixed pixels
    stage_pix = '{16'h1234, 16'h5678, 16'h9ABC};
    load_frame();
    start_pulse(1'b0, 3);
    push_frame();
    wait_idle(200);

    // Synced frame; the early strobe must be ignored
    stage_pix = '{16'hA55A, 16'h0FF0};
    load_frame();
    fmark_pulse(1'b0);
    start_pulse(1'b1, 2);
    repeat (6) begin
      @(negedge clk);
      chk("sync_wait_no_valid", 32'(phy_valid), 32'h0);
      tick();
    end
    phy_fmark_stb = 1'b1;
    push_frame();
    @(negedge clk);
    chk("valid_during_strobe_cycle", 32'(phy_valid), 32'h0);
    tick();
    phy_fmark_stb = 1'b0;
    @(negedge clk);
    chk("first_byte_after_strobe{valid,data}", 32'({phy_valid, phy_data}), 32'h1A5);
    tick();
    wait_idle(200);

    // Commands preempt FM_WAIT, then the wait resumes
    rand_frame(2);
    load_frame();
    start_pulse(1'b1, 2);
    repeat (3) tick();
    cmd_stage = '{9'h136, 9'h048};
    cmd_send();
    repeat (4) begin
      @(negedge clk);
      chk("fm_wait_resumed_no_valid", 32'(phy_valid), 32'h0);
      tick();
    end
    fmark_pulse(1'b1);
    wait_idle(200);

    // Pending start together with a command: command first
    rand_frame(2);
    load_frame();
    start_pulse(1'b0, 2);
    cmd_stage = '{9'h0B0, 9'h1C1, 9'h1C2};
    cmd_send();
    push_frame();
    wait_idle(200);

    // Command lock during PIX, ignored second start, random backpressure
    rdy_rand = 1'b1;
    rand_frame(4);
    load_frame();
    start_pulse(1'b0, 4);
    push_frame();
    wait_xfers(1);
    start_pulse(1'b0, 5);
    cmd_stage = '{9'h02C, 9'h1EE};
    cmd_send();
    wait_idle(400);

    // Randomised mix of frames (with stalls) and command sequences
    gap_en = 1'b1;
    for (int it = 0; it < 16; it++) begin
      if ($urandom_range(0, 2) == 0) begin
        for (int b = 0, nb = $urandom_range(1, 4); b < nb; b++)
          cmd_stage.push_back(9'($urandom));
        cmd_send();
      end else begin
        int  n = $urandom_range(0, 6);
        bit  s = 1'($urandom_range(0, 1));
        rand_frame(n);
        load_frame();
        start_pulse(s, n);
        if (s && n != 0) begin
          repeat ($urandom_range(1, 5)) tick();
          fmark_pulse(1'b1);
        end else begin
          push_frame();
        end
      end
      wait_idle(600);
    end

    // Reset mid-frame after five bytes
    gap_en = 1'b0;
    rdy_rand = 1'b0;
    rand_frame(4);
    load_frame();
    start_pulse(1'b0, 4);
    push_frame();
    wait_xfers(5);
    #3;
    rst = 1'b1;
    #1;
    chk("async_rst_phy_valid", 32'(phy_valid), 32'h0);
    chk("async_rst_ctl_busy", 32'(ctl_busy), 32'h0);
    chk("async_rst_pix_ready", 32'(pix_ready), 32'h0);
    chk("async_rst_cmd_ready", 32'(cmd_ready), 32'h0);
    chk("async_rst_ctl_done", 32'(ctl_done), 32'h0);
    exp_q.delete();
    done_due = 1'b0;
    zero_tok = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    rst = 1'b0;
    repeat (5) tick();
    stage_pix = '{16'hC3D4};
    load_frame();
    start_pulse(1'b0, 1);
    push_frame();
    wait_idle(200);

    chk("final_expected_queue_empty", 32'(exp_q.size()), 32'h0);
    report();
    $finish;
  end

endmodule
